// File: rtl/s32x_fb_ctrl_pkg.sv
// Shared types for the 32X framebuffer memory controller: arbiter states and
// the per-port write-buffer entry.
package s32x_fb_ctrl_pkg;

   // Port word-address width carried in a write-buffer entry
   localparam int FBC_AW = 16;

   typedef enum logic {
      FBC_IDLE,
      FBC_BUSY
   } FBC_STATE_t;

   // One buffered write: address, data, byte enables, valid
   typedef struct packed {
      logic [FBC_AW-1:0] A;
      logic [15:0]       D;
      logic [1:0]        BE;
      logic              V;
   } FBC_WB_t;

endpackage

// File: rtl/s32x_fb_port.sv
// One VDP framebuffer port: turns level WE/RD strobes into single write and
// read entries (WB, RP), tracks the last write tuple and last read address,
// and flags write overruns.
module s32x_fb_port
   import s32x_fb_ctrl_pkg::*;
#(
   parameter int AW      = FBC_AW,
   parameter bit RD_HOLD = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] a,
   input  logic [15:0]   wdata,
   input  logic [1:0]    we,
   input  logic          rd,
   input  logic          wb_ack,
   input  logic          rp_ack,
   output FBC_WB_t       wb,
   output logic [AW-1:0] rp_a,
   output logic          rp_v,
   output logic          ovr
);

   logic [1:0]    we_prev;
   logic          rd_prev;
   logic [AW-1:0] lw_a;
   logic [15:0]   lw_d;
   logic [1:0]    lw_be;
   logic [AW-1:0] lr_a;
   logic          lr_v;
   logic          wr_cap;
   logic          rd_cap;
   logic          rd_new;

   // New write on WE rising or whenever the held tuple changes (fill bursts)
   assign wr_cap = (we != 2'b00) &&
                   ((we_prev == 2'b00) || ({a, wdata, we} != {lw_a, lw_d, lw_be}));

   // New read on RD rising, address change, or after a write invalidated LR;
   // with RD_HOLD=0 a held RD keeps re-reading whenever no read is pending
   assign rd_new = !rd_prev || !lr_v || (a != lr_a);
   assign rd_cap = rd && (rd_new || (!RD_HOLD && !rp_v));

   // Capture and retire entries; a capture on the ACK cycle keeps the entry valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_prev <= 2'b00;
         rd_prev <= 1'b0;
         lw_a    <= '0;
         lw_d    <= '0;
         lw_be   <= 2'b00;
         lr_a    <= '0;
         lr_v    <= 1'b0;
         wb      <= '0;
         rp_a    <= '0;
         rp_v    <= 1'b0;
         ovr     <= 1'b0;
      end else begin
         we_prev <= we;
         rd_prev <= rd;
         if (wr_cap) begin
            wb    <= '{A: a, D: wdata, BE: we, V: 1'b1};
            lw_a  <= a;
            lw_d  <= wdata;
            lw_be <= we;
            if (wb.V && !wb_ack) ovr <= 1'b1;
            // Writing the address being displayed forces the next RD to re-read
            if (lr_v && (a == lr_a)) lr_v <= 1'b0;
         end else if (wb_ack) begin
            wb.V <= 1'b0;
         end
         // Placed after the write path so a same-cycle read re-arms LR
         if (rd_cap) begin
            rp_a <= a;
            rp_v <= 1'b1;
            lr_a <= a;
            lr_v <= 1'b1;
         end else if (rp_ack) begin
            rp_v <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/s32x_fb_ctrl.sv
// 32X framebuffer controller: two VDP ports (FB0 -> bank 0, FB1 -> bank 1)
// arbitrated round-robin onto one single-outstanding external memory port,
// with held read-data latches per port.
module s32x_fb_ctrl
   import s32x_fb_ctrl_pkg::*;
#(
   parameter int AW      = FBC_AW,
   parameter bit RD_HOLD = 1'b1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [AW-1:0] FB0_A,
   input  logic [15:0]   FB0_DO,
   input  logic [1:0]    FB0_WE,
   input  logic          FB0_RD,
   output logic [15:0]   FB0_DI,
   input  logic [AW-1:0] FB1_A,
   input  logic [15:0]   FB1_DO,
   input  logic [1:0]    FB1_WE,
   input  logic          FB1_RD,
   output logic [15:0]   FB1_DI,
   output logic [AW:0]   MEM_A,
   output logic [15:0]   MEM_DO,
   output logic [1:0]    MEM_BE,
   output logic          MEM_WE,
   output logic          MEM_REQ,
   input  logic          MEM_ACK,
   input  logic [15:0]   MEM_DI,
   output logic [1:0]    OVR
);

   FBC_STATE_t    state;
   logic          ptr;
   logic          sel_port;
   logic          sel_wr;
   logic          pick;
   logic          ack_now;

   logic [AW-1:0] port_a  [2];
   logic [15:0]   port_do [2];
   logic [1:0]    port_we [2];
   logic [1:0]    port_rd;
   FBC_WB_t       wb      [2];
   logic [AW-1:0] rp_a    [2];
   logic [1:0]    rp_v;
   logic [1:0]    req_v;
   logic [1:0]    wb_ack;
   logic [1:0]    rp_ack;
   logic [15:0]   di_reg  [2];

   assign port_a[0]  = FB0_A;
   assign port_a[1]  = FB1_A;
   assign port_do[0] = FB0_DO;
   assign port_do[1] = FB1_DO;
   assign port_we[0] = FB0_WE;
   assign port_we[1] = FB1_WE;
   assign port_rd    = {FB1_RD, FB0_RD};
   assign FB0_DI     = di_reg[0];
   assign FB1_DI     = di_reg[1];

   assign ack_now = (state == FBC_BUSY) && MEM_ACK;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign req_v[gi]  = wb[gi].V | rp_v[gi];
         assign wb_ack[gi] = ack_now && sel_wr && (sel_port == 1'(gi));
         assign rp_ack[gi] = ack_now && !sel_wr && (sel_port == 1'(gi));

         s32x_fb_port #(
            .AW      (AW),
            .RD_HOLD (RD_HOLD)
         ) u_port (
            .clk    (CLK),
            .rst_n  (RST_N),
            .a      (port_a[gi]),
            .wdata  (port_do[gi]),
            .we     (port_we[gi]),
            .rd     (port_rd[gi]),
            .wb_ack (wb_ack[gi]),
            .rp_ack (rp_ack[gi]),
            .wb     (wb[gi]),
            .rp_a   (rp_a[gi]),
            .rp_v   (rp_v[gi]),
            .ovr    (OVR[gi])
         );
      end
   endgenerate

   // Round-robin choice when both ports request; a lone requester always wins
   always_comb begin
      pick = ptr;
      if (req_v[0] != req_v[1]) pick = req_v[1];
   end

   // Arbiter FSM: grant in IDLE, hold the request stable in BUSY until ACK
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= FBC_IDLE;
         ptr       <= 1'b0;
         sel_port  <= 1'b0;
         sel_wr    <= 1'b0;
         MEM_REQ   <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_A     <= '0;
         MEM_DO    <= '0;
         MEM_BE    <= 2'b00;
         di_reg[0] <= '0;
         di_reg[1] <= '0;
      end else begin
         case (state)
            FBC_IDLE: begin
               if (req_v != 2'b00) begin
                  sel_port <= pick;
                  sel_wr   <= wb[pick].V;
                  MEM_REQ  <= 1'b1;
                  MEM_WE   <= wb[pick].V;
                  // Buffered write goes ahead of the pending read on the same port
                  if (wb[pick].V) begin
                     MEM_A  <= {pick, wb[pick].A};
                     MEM_DO <= wb[pick].D;
                     MEM_BE <= wb[pick].BE;
                  end else begin
                     MEM_A  <= {pick, rp_a[pick]};
                     MEM_DO <= '0;
                     MEM_BE <= 2'b11;
                  end
                  ptr   <= ~ptr;
                  state <= FBC_BUSY;
               end
            end
            FBC_BUSY: begin
               if (MEM_ACK) begin
                  MEM_REQ <= 1'b0;
                  if (!sel_wr) di_reg[sel_port] <= MEM_DI;
                  state <= FBC_IDLE;
               end
            end
            default: state <= FBC_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_s32x_fb_ctrl.sv
// Directed bench for s32x_fb_ctrl with a behavioural memory responder.
module tb_s32x_fb_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] FB0_A, FB0_DO, FB1_A, FB1_DO;
   logic [1:0]  FB0_WE, FB1_WE;
   logic        FB0_RD, FB1_RD;
   logic [15:0] FB0_DI, FB1_DI;
   logic [16:0] MEM_A;
   logic [15:0] MEM_DO;
   logic [1:0]  MEM_BE;
   logic        MEM_WE, MEM_REQ;
   logic        MEM_ACK;
   logic [15:0] MEM_DI;
   logic [1:0]  OVR;

   logic        ack_resp = 1'b0;
   logic        ack_late = 1'b0;
   logic        resp_en  = 1'b1;
   int          ack_delay = 0;
   int          wait_cnt  = 0;

   logic [15:0] mem [logic [16:0]];
   int          txn_cnt = 0;
   logic [16:0] log_a  [64];
   logic [15:0] log_d  [64];
   logic [1:0]  log_be [64];
   logic        log_we [64];

   int checks   = 0;
   int failures = 0;

   assign MEM_ACK = ack_resp | ack_late;

   always #5 CLK = ~CLK;

   s32x_fb_ctrl dut (
      .CLK(CLK), .RST_N(RST_N),
      .FB0_A(FB0_A), .FB0_DO(FB0_DO), .FB0_WE(FB0_WE), .FB0_RD(FB0_RD), .FB0_DI(FB0_DI),
      .FB1_A(FB1_A), .FB1_DO(FB1_DO), .FB1_WE(FB1_WE), .FB1_RD(FB1_RD), .FB1_DI(FB1_DI),
      .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE),
      .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK), .MEM_DI(MEM_DI), .OVR(OVR)
   );

   function automatic logic [15:0] mem_rd(input logic [16:0] addr);
      if (mem.exists(addr)) return mem[addr];
      return addr[15:0] ^ 16'hA5A5;
   endfunction

   // Memory responder: ACK after ack_delay REQ cycles, one cycle wide
   initial begin
      MEM_DI = 16'h0000;
      forever begin
         @(negedge CLK);
         if (ack_resp) begin
            ack_resp = 1'b0;
         end else if (MEM_REQ && resp_en) begin
            if (wait_cnt >= ack_delay) begin
               wait_cnt = 0;
               ack_resp = 1'b1;
               if (MEM_WE) mem[MEM_A] = MEM_DO;
               else        MEM_DI = mem_rd(MEM_A);
               if (txn_cnt < 64) begin
                  log_a[txn_cnt]  = MEM_A;
                  log_d[txn_cnt]  = MEM_WE ? MEM_DO : MEM_DI;
                  log_be[txn_cnt] = MEM_BE;
                  log_we[txn_cnt] = MEM_WE;
               end
               $display("TXN %0d %s A=%05h D=%04h BE=%b", txn_cnt, MEM_WE ? "WR" : "RD",
                        MEM_A, MEM_WE ? MEM_DO : MEM_DI, MEM_BE);
               txn_cnt++;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      RST_N = 1'b0;
      FB0_A = '0; FB0_DO = '0; FB0_WE = '0; FB0_RD = 1'b0;
      FB1_A = '0; FB1_DO = '0; FB1_WE = '0; FB1_RD = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic wait_txns(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge CLK); #1;
         if (txn_cnt >= target && !MEM_REQ) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (4) @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      @(posedge CLK); #1;
      checks++;
      if (MEM_REQ !== 1'b0 || MEM_WE !== 1'b0 || MEM_A !== 17'h0) begin
         failures++;
         $display("FAIL reset_mem_ctl got req=%b we=%b a=%05h exp 0/0/00000", MEM_REQ, MEM_WE, MEM_A);
      end
      checks++;
      if (MEM_DO !== 16'h0 || MEM_BE !== 2'b00 || OVR !== 2'b00) begin
         failures++;
         $display("FAIL reset_mem_data got do=%04h be=%b ovr=%b exp 0000/00/00", MEM_DO, MEM_BE, OVR);
      end
      checks++;
      if (FB0_DI !== 16'h0 || FB1_DI !== 16'h0) begin
         failures++;
         $display("FAIL reset_di got fb0=%04h fb1=%04h exp 0000/0000", FB0_DI, FB1_DI);
      end
   endtask

   task automatic test_read();
      int base;
      @(negedge CLK);
      base = txn_cnt;
      FB0_A = 16'h0010; FB0_RD = 1'b1;
      @(posedge CLK); #1;   // capture
      @(posedge CLK); #1;   // grant
      checks++;
      if (MEM_REQ !== 1'b1 || MEM_A !== 17'h00010 || MEM_WE !== 1'b0 || MEM_BE !== 2'b11) begin
         failures++;
         $display("FAIL read_issue got req=%b a=%05h we=%b be=%b exp 1/00010/0/11", MEM_REQ, MEM_A, MEM_WE, MEM_BE);
      end
      checks++;
      if (FB0_DI !== 16'h0000) begin
         failures++;
         $display("FAIL read_early got di=%04h exp 0000", FB0_DI);
      end
      @(posedge CLK); #1;   // ACK taken
      checks++;
      if (FB0_DI !== 16'hA5B5 || MEM_REQ !== 1'b0) begin
         failures++;
         $display("FAIL read_latency got di=%04h req=%b exp A5B5/0", FB0_DI, MEM_REQ);
      end
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (txn_cnt - base !== 1) begin
         failures++;
         $display("FAIL read_hold_no_reissue got txns=%0d exp 1", txn_cnt - base);
      end
      @(negedge CLK);
      FB0_RD = 1'b0;
   endtask

   task automatic test_single_write();
      int base;
      bit ok;
      @(negedge CLK);
      base = txn_cnt;
      FB1_A = 16'h1234; FB1_DO = 16'h00AB; FB1_WE = 2'b01;
      repeat (6) @(negedge CLK);
      FB1_WE = 2'b00;
      wait_txns(base + 1, 20, ok);
      checks++;
      if (!ok || txn_cnt - base !== 1) begin
         failures++;
         $display("FAIL single_write_count got txns=%0d ok=%b exp 1", txn_cnt - base, ok);
      end else begin
         checks++;
         if (log_a[base] !== 17'h11234 || log_we[base] !== 1'b1 ||
             log_d[base] !== 16'h00AB || log_be[base] !== 2'b01) begin
            failures++;
            $display("FAIL single_write_txn got a=%05h we=%b d=%04h be=%b exp 11234/1/00AB/01",
                     log_a[base], log_we[base], log_d[base], log_be[base]);
         end
      end
   endtask

   task automatic test_fill_burst();
      int base;
      bit ok;
      @(negedge CLK);
      base = txn_cnt;
      for (int i = 0; i < 5; i++) begin
         FB1_A = 16'h0100 + 16'(i); FB1_DO = 16'hC000 + 16'(i); FB1_WE = 2'b11;
         repeat (3) @(negedge CLK);
      end
      FB1_WE = 2'b00;
      wait_txns(base + 5, 30, ok);
      checks++;
      if (!ok || txn_cnt - base !== 5) begin
         failures++;
         $display("FAIL burst_count got txns=%0d ok=%b exp 5", txn_cnt - base, ok);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_a[base+i] !== 17'h10100 + 17'(i) || log_d[base+i] !== 16'hC000 + 16'(i) ||
                log_we[base+i] !== 1'b1 || log_be[base+i] !== 2'b11) begin
               failures++;
               $display("FAIL burst_txn%0d got a=%05h d=%04h we=%b be=%b exp %05h/%04h/1/11", i,
                        log_a[base+i], log_d[base+i], log_we[base+i], log_be[base+i],
                        17'h10100 + 17'(i), 16'hC000 + 16'(i));
            end
         end
      end
      checks++;
      if (OVR !== 2'b00) begin
         failures++;
         $display("FAIL burst_ovr got ovr=%b exp 00", OVR);
      end
   endtask

   task automatic test_arbitration();
      int base;
      bit ok;
      apply_reset();
      base = txn_cnt;
      FB0_A = 16'h0030; FB0_RD = 1'b1;
      FB1_A = 16'h0040; FB1_DO = 16'hBEEF; FB1_WE = 2'b11;
      @(negedge CLK);
      FB1_WE = 2'b00;
      wait_txns(base + 2, 20, ok);
      checks++;
      if (!ok || txn_cnt - base !== 2) begin
         failures++;
         $display("FAIL arb_count got txns=%0d ok=%b exp 2", txn_cnt - base, ok);
      end else begin
         checks++;
         if (log_a[base] !== 17'h00030 || log_we[base] !== 1'b0) begin
            failures++;
            $display("FAIL arb_first got a=%05h we=%b exp 00030/0", log_a[base], log_we[base]);
         end
         checks++;
         if (log_a[base+1] !== 17'h10040 || log_we[base+1] !== 1'b1 || log_d[base+1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL arb_second got a=%05h we=%b d=%04h exp 10040/1/BEEF",
                     log_a[base+1], log_we[base+1], log_d[base+1]);
         end
      end
      checks++;
      if (FB0_DI !== 16'hA595 || FB1_DI !== 16'h0000) begin
         failures++;
         $display("FAIL arb_di got fb0=%04h fb1=%04h exp A595/0000", FB0_DI, FB1_DI);
      end
      @(negedge CLK);
      FB0_RD = 1'b0;
   endtask

   task automatic test_coherency();
      int base;
      bit ok;
      @(negedge CLK);
      base = txn_cnt;
      FB0_A = 16'h0020; FB0_RD = 1'b1;
      wait_txns(base + 1, 20, ok);
      checks++;
      if (!ok || FB0_DI !== 16'hA585) begin
         failures++;
         $display("FAIL coh_first_read got di=%04h ok=%b exp A585", FB0_DI, ok);
      end
      @(negedge CLK);
      base = txn_cnt;
      FB0_DO = 16'h1357; FB0_WE = 2'b11;
      @(negedge CLK);
      FB0_WE = 2'b00;
      wait_txns(base + 2, 20, ok);
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (!ok || txn_cnt - base !== 2) begin
         failures++;
         $display("FAIL coh_count got txns=%0d ok=%b exp 2", txn_cnt - base, ok);
      end else begin
         checks++;
         if (log_a[base] !== 17'h00020 || log_we[base] !== 1'b1 || log_d[base] !== 16'h1357 ||
             log_a[base+1] !== 17'h00020 || log_we[base+1] !== 1'b0) begin
            failures++;
            $display("FAIL coh_order got %05h/%b/%04h then %05h/%b exp 00020/1/1357 then 00020/0",
                     log_a[base], log_we[base], log_d[base], log_a[base+1], log_we[base+1]);
         end
      end
      checks++;
      if (FB0_DI !== 16'h1357) begin
         failures++;
         $display("FAIL coh_reread_data got di=%04h exp 1357", FB0_DI);
      end
      @(negedge CLK);
      FB0_RD = 1'b0;
   endtask

   task automatic test_overrun();
      int base;
      bit ok;
      @(negedge CLK);
      base = txn_cnt;
      ack_delay = 10;
      FB1_A = 16'h0050; FB1_RD = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      FB0_A = 16'h0060; FB0_DO = 16'h1111; FB0_WE = 2'b11;
      @(negedge CLK);
      FB0_A = 16'h0061; FB0_DO = 16'h2222;
      @(negedge CLK);
      FB0_WE = 2'b00;
      checks++;
      if (OVR !== 2'b01 || MEM_REQ !== 1'b1) begin
         failures++;
         $display("FAIL ovr_flag got ovr=%b req=%b exp 01/1", OVR, MEM_REQ);
      end
      wait_txns(base + 2, 60, ok);
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (!ok || txn_cnt - base !== 2) begin
         failures++;
         $display("FAIL ovr_count got txns=%0d ok=%b exp 2", txn_cnt - base, ok);
      end else begin
         checks++;
         if (log_a[base] !== 17'h10050 || log_we[base] !== 1'b0 ||
             log_a[base+1] !== 17'h00061 || log_we[base+1] !== 1'b1 || log_d[base+1] !== 16'h2222) begin
            failures++;
            $display("FAIL ovr_order got %05h/%b then %05h/%b/%04h exp 10050/0 then 00061/1/2222",
                     log_a[base], log_we[base], log_a[base+1], log_we[base+1], log_d[base+1]);
         end
      end
      checks++;
      if (OVR !== 2'b01) begin
         failures++;
         $display("FAIL ovr_sticky got ovr=%b exp 01", OVR);
      end
      @(negedge CLK);
      FB1_RD = 1'b0;
      ack_delay = 0;
   endtask

   task automatic test_reset_busy();
      int base;
      int req_seen;
      @(negedge CLK);
      resp_en = 1'b0;
      base = txn_cnt;
      FB0_A = 16'h0070; FB0_RD = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (MEM_REQ !== 1'b1) begin
         failures++;
         $display("FAIL rstb_busy got req=%b exp 1", MEM_REQ);
      end
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (MEM_REQ !== 1'b0 || MEM_A !== 17'h0 || OVR !== 2'b00) begin
         failures++;
         $display("FAIL rstb_async got req=%b a=%05h ovr=%b exp 0/00000/00", MEM_REQ, MEM_A, OVR);
      end
      FB0_RD = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      req_seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge CLK); #1;
         if (MEM_REQ) req_seen++;
      end
      checks++;
      if (req_seen !== 0 || txn_cnt !== base) begin
         failures++;
         $display("FAIL rstb_quiet got req_cycles=%0d txns=%0d exp 0/0", req_seen, txn_cnt - base);
      end
      @(negedge CLK);
      ack_late = 1'b1;
      @(negedge CLK);
      ack_late = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (FB0_DI !== 16'h0 || FB1_DI !== 16'h0 || MEM_REQ !== 1'b0) begin
         failures++;
         $display("FAIL rstb_late_ack got fb0=%04h fb1=%04h req=%b exp 0000/0000/0", FB0_DI, FB1_DI, MEM_REQ);
      end
      resp_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_read();
      test_single_write();
      test_fill_burst();
      test_arbitration();
      test_coherency();
      test_overrun();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
